// File: rtl/ps2_sb_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_sb_ctrl
// PS/2 keyboard receiver with a small memory-mapped register interface.
// Frames (start, 8 data bits LSB first, odd parity, stop) are sampled on
// falling edges of the synchronized PS/2 clock. Each accepted scan code is
// latched, flagged as unread and raises an interrupt.
//
// Ports
//   clk_i               system clock, rising edge
//   rst_i               synchronous active-high reset
//   req_i               bus request
//   write_enable_i      bus write strobe (qualified by req_i)
//   addr_i[31:0]        byte address, bits [23:0] decoded
//   write_data_i[31:0]  bus write data
//   read_data_o[31:0]   registered read data, held until the next read
//   kclk_i, kdata_i     asynchronous PS/2 clock and data lines
//   interrupt_request_o new scan code pending
//   interrupt_return_i  interrupt acknowledge pulse
//
// Register map
//   0x00 R  {24'b0, scan_code}   read clears unread and interrupt
//   0x04 RW {31'b0, unread}      write 0 clears unread
//   0x08 R  {31'b0, overrun}     read clears overrun
//   0x24 W  write 1 = soft reset
// ----------------------------------------------------------------------------
module ps2_sb_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    input  logic        kclk_i,
    input  logic        kdata_i,
    output logic        interrupt_request_o,
    input  logic        interrupt_return_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [23:0] ADDR_SCAN    = 24'h00_0000;
    localparam logic [23:0] ADDR_UNREAD  = 24'h00_0004;
    localparam logic [23:0] ADDR_OVERRUN = 24'h00_0008;
    localparam logic [23:0] ADDR_SRST    = 24'h00_0024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Synchronizers; the extra kclk_prev_q flop provides the edge reference.
    logic kclk_s1_q, kclk_s2_q, kclk_prev_q;
    logic kdata_s1_q, kdata_s2_q;

    state_e       state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]   scan_code_q, scan_code_d;
    logic         unread_q, unread_d;
    logic         overrun_q, overrun_d;
    logic         irq_q, irq_d;
    logic [31:0]  read_data_q, read_data_d;

    logic kclk_fall;
    logic accept;
    logic rd, wr, soft_rst;
    logic [23:0] addr;
    logic unused_addr_hi;

    assign unused_addr_hi = ^addr_i[31:24];
    assign addr      = addr_i[23:0];
    assign rd        = req_i && !write_enable_i;
    assign wr        = req_i && write_enable_i;
    assign soft_rst  = wr && (addr == ADDR_SRST) && (write_data_i == 32'd1);
    assign kclk_fall = kclk_prev_q && !kclk_s2_q;

    // NOTE: every variable driven here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        scan_code_d = scan_code_q;
        unread_d    = unread_q;
        overrun_d   = overrun_q;
        irq_d       = irq_q;
        read_data_d = read_data_q;
        accept      = 1'b0;

        // Stall watchdog: only armed while a frame is in progress.
        if (kclk_fall) begin
            tmo_d = '0;
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        if (kclk_fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!kdata_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {kdata_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_d = kdata_s2_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    accept  = kdata_s2_q && (^{shift_q, parity_q});
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Bus reads return the value before any clear caused by the read.
        if (rd) begin
            unique case (addr)
                ADDR_SCAN: begin
                    read_data_d = {24'b0, scan_code_q};
                    unread_d    = 1'b0;
                    irq_d       = 1'b0;
                end
                ADDR_UNREAD:  read_data_d = {31'b0, unread_q};
                ADDR_OVERRUN: begin
                    read_data_d = {31'b0, overrun_q};
                    overrun_d   = 1'b0;
                end
                default: read_data_d = 32'd0;
            endcase
        end

        if (wr && (addr == ADDR_UNREAD) && (write_data_i == 32'd0)) unread_d = 1'b0;
        if (interrupt_return_i) irq_d = 1'b0;

        // Acceptance is applied last so it wins over any same-cycle clear.
        if (accept) begin
            scan_code_d = shift_q;
            unread_d    = 1'b1;
            irq_d       = 1'b1;
            if (unread_q) overrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (synchronizer chain).
    always_ff @(posedge clk_i) begin
        if (rst_i || soft_rst) begin
            kclk_s1_q   <= 1'b1;
            kclk_s2_q   <= 1'b1;
            kclk_prev_q <= 1'b1;
            kdata_s1_q  <= 1'b1;
            kdata_s2_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            scan_code_q <= '0;
            unread_q    <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            kclk_s1_q   <= kclk_i;
            kclk_s2_q   <= kclk_s1_q;
            kclk_prev_q <= kclk_s2_q;
            kdata_s1_q  <= kdata_i;
            kdata_s2_q  <= kdata_s1_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            scan_code_q <= scan_code_d;
            unread_q    <= unread_d;
            overrun_q   <= overrun_d;
            irq_q       <= irq_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data_o         = read_data_q;
    assign interrupt_request_o = irq_q;

endmodule

// File: tb/tb_ps2_sb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_sb_ctrl
// Directed bench for ps2_sb_ctrl: drives PS/2 frames bit by bit, exercises the
// register map and compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ps2_sb_ctrl;

    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        kclk = 1'b1;
    logic        kdata = 1'b1;
    logic        irq;
    logic        irq_ret = 1'b0;

    int tests = 0;
    int failed = 0;
    logic [31:0] rd;

    ps2_sb_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_i               (req),
        .write_enable_i      (we),
        .addr_i              (addr),
        .write_data_i        (wdata),
        .read_data_o         (rdata),
        .kclk_i              (kclk),
        .kdata_i             (kdata),
        .interrupt_request_o (irq),
        .interrupt_return_i  (irq_ret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One PS/2 bit: data settles, kclk low for 4 cycles, then high again.
    task automatic ps2_bit(input logic b);
        @(negedge clk); kdata = b;
        repeat (3) @(negedge clk);
        kclk = 1'b0;
        repeat (4) @(negedge clk);
        kclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic ps2_head(input logic [7:0] d, input logic par_ok);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par_ok ? ~(^d) : (^d));
    endtask

    task automatic ps2_frame(input logic [7:0] d, input logic par_ok, input logic stop);
        ps2_head(d, par_ok);
        ps2_bit(stop);
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk); req = 1'b0;
        d = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk); req = 1'b0; we = 1'b0;
    endtask

    // Full frame whose stop-bit edge is seen in the same cycle as a read of 0x00.
    // kclk falls at negedge N; the edge is visible after the 2nd rising edge and
    // is acted on at the 3rd, so the request is raised at negedge N+2.
    task automatic ps2_frame_rd00(input logic [7:0] d, output logic [31:0] r);
        ps2_head(d, 1'b1);
        @(negedge clk); kdata = 1'b1;
        repeat (3) @(negedge clk);
        kclk = 1'b0;
        repeat (2) @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0;
        @(negedge clk); req = 1'b0;
        r = rdata;
        repeat (2) @(negedge clk);
        kclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        bus_read(32'h00, rd); check("rst_scan", rd, 32'h0);
        bus_read(32'h04, rd); check("rst_unread", rd, 32'h0);
        bus_read(32'h08, rd); check("rst_overrun", rd, 32'h0);

        // Valid 0x1C frame
        ps2_frame(8'h1C, 1'b1, 1'b1);
        check("1c_irq", {31'b0, irq}, 32'h1);
        bus_read(32'h04, rd); check("1c_unread", rd, 32'h1);
        bus_read(32'h00, rd); check("1c_scan", rd, 32'h1C);
        bus_read(32'h04, rd); check("1c_unread_clr", rd, 32'h0);
        check("1c_irq_clr", {31'b0, irq}, 32'h0);
        repeat (5) @(negedge clk);
        check("rdata_hold", rdata, 32'h0);

        // Bad parity and bad stop bit from a fresh reset
        do_reset();
        ps2_frame(8'h1C, 1'b0, 1'b1);
        check("badpar_irq", {31'b0, irq}, 32'h0);
        ps2_frame(8'h33, 1'b1, 1'b0);
        check("badstop_irq", {31'b0, irq}, 32'h0);
        bus_read(32'h00, rd); check("bad_scan", rd, 32'h0);
        bus_read(32'h04, rd); check("bad_unread", rd, 32'h0);

        // Overrun
        ps2_frame(8'h1C, 1'b1, 1'b1);
        ps2_frame(8'hF0, 1'b1, 1'b1);
        bus_read(32'h00, rd); check("ovr_scan", rd, 32'hF0);
        bus_read(32'h08, rd); check("ovr_set", rd, 32'h1);
        bus_read(32'h08, rd); check("ovr_clr", rd, 32'h0);

        // Interrupt acknowledge leaves unread set; write semantics of 0x04
        ps2_frame(8'h12, 1'b1, 1'b1);
        check("ack_irq_pre", {31'b0, irq}, 32'h1);
        @(negedge clk); irq_ret = 1'b1;
        @(negedge clk); irq_ret = 1'b0;
        check("ack_irq", {31'b0, irq}, 32'h0);
        bus_read(32'h04, rd); check("ack_unread", rd, 32'h1);
        bus_write(32'h04, 32'h1);
        bus_read(32'h04, rd); check("wr04_1_ignored", rd, 32'h1);
        bus_write(32'h04, 32'h0);
        bus_read(32'h04, rd); check("wr04_0_clr", rd, 32'h0);
        bus_read(32'h08, rd); check("ack_no_ovr", rd, 32'h0);

        // Acceptance coinciding with a read of 0x00
        ps2_frame_rd00(8'h45, rd);
        check("coinc_stale", rd, 32'h12);
        check("coinc_irq", {31'b0, irq}, 32'h1);
        bus_read(32'h04, rd); check("coinc_unread", rd, 32'h1);
        bus_read(32'h00, rd); check("coinc_scan", rd, 32'h45);

        // Partial frame abandoned by the timeout
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO + 5) @(negedge clk);
        ps2_frame(8'h29, 1'b1, 1'b1);
        bus_read(32'h00, rd); check("tmo_scan", rd, 32'h29);
        bus_read(32'h08, rd); check("tmo_no_ovr", rd, 32'h0);

        // Soft reset mid-frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        bus_read(32'h00, rd);
        bus_write(32'h24, 32'h1);
        check("srst_rdata", rdata, 32'h0);
        check("srst_irq", {31'b0, irq}, 32'h0);
        bus_read(32'h00, rd); check("srst_scan", rd, 32'h0);
        ps2_frame(8'h5A, 1'b1, 1'b1);
        bus_read(32'h00, rd); check("srst_5a", rd, 32'h5A);
        bus_write(32'h24, 32'h2);
        bus_read(32'h00, rd); check("srst2_noeffect", rd, 32'h5A);

        // Decode: unmapped, ignored upper bits, read-only write
        bus_read(32'h10, rd); check("unmapped", rd, 32'h0);
        bus_read(32'h0100_0000, rd); check("upper_ignored", rd, 32'h5A);
        bus_write(32'h00, 32'hFF);
        bus_read(32'h00, rd); check("ro_write", rd, 32'h5A);

        // Hard reset mid-frame, then a clean frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        do_reset();
        check("hrst_irq", {31'b0, irq}, 32'h0);
        ps2_frame(8'h77, 1'b1, 1'b1);
        check("hrst_irq_new", {31'b0, irq}, 32'h1);
        bus_read(32'h00, rd); check("hrst_scan", rd, 32'h77);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
